// File: rtl/robot_wall_follower.sv
// Wall-following robot controller: debounced head/side sensors feeding a
// Moore FSM that advances along a wall, turns away from obstacles and
// searches for the wall when it is lost.
// Optional feature macro: ROBOT_STUCK_DETECT_EN (turn counter + STUCK state).
module robot_wall_follower #(
  parameter int unsigned DEB_LEN  = 3,
  parameter int unsigned TURN_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       side_sel,
  input  logic       h,
  input  logic       l,
  output logic       a,
  output logic       r,
  output logic       dir,
  output logic       stuck,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FOLLOW     = 3'd1,
    S_AVOID      = 3'd2,
    S_SEARCH_ROT = 3'd3,
    S_SEARCH_ADV = 3'd4,
    S_STUCK      = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               hf_q, hf_d, lf_q, lf_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d, lcnt_q, lcnt_d;

`ifdef ROBOT_STUCK_DETECT_EN
  localparam int unsigned TURN_W = (TURN_MAX > 1) ? $clog2(TURN_MAX) : 1;
  logic [TURN_W-1:0]  turn_q, turn_d;
`endif

  // Head sensor debounce: filtered value flips after DEB_LEN differing samples
  always_comb begin
    hf_d   = hf_q;
    hcnt_d = '0;
    if (h != hf_q) begin
      if (hcnt_q == CNT_W'(DEB_LEN - 1)) begin
        hf_d = h;
      end else begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end
  end

  // Side sensor debounce, identical behaviour to the head filter
  always_comb begin
    lf_d   = lf_q;
    lcnt_d = '0;
    if (l != lf_q) begin
      if (lcnt_q == CNT_W'(DEB_LEN - 1)) begin
        lf_d = l;
      end else begin
        lcnt_d = lcnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic; head obstacle always wins over wall presence
  always_comb begin
    state_d = state_q;
`ifdef ROBOT_STUCK_DETECT_EN
    turn_d  = '0;
`endif
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_AVOID: begin
          if (hf_q) begin
`ifdef ROBOT_STUCK_DETECT_EN
            if (turn_q == TURN_W'(TURN_MAX - 1)) begin
              state_d = S_STUCK;
            end else begin
              state_d = S_AVOID;
              turn_d  = turn_q + TURN_W'(1);
            end
`else
            state_d = S_AVOID;
`endif
          end else if (lf_q) begin
            state_d = S_FOLLOW;
          end else begin
            state_d = S_SEARCH_ROT;
          end
        end
        S_STUCK: begin
          state_d = S_STUCK;
        end
        S_SEARCH_ROT: begin
          if (hf_q)      state_d = S_AVOID;
          else if (lf_q) state_d = S_FOLLOW;
          else           state_d = S_SEARCH_ADV;
        end
        default: begin
          if (hf_q)      state_d = S_AVOID;
          else if (lf_q) state_d = S_FOLLOW;
          else           state_d = S_SEARCH_ROT;
        end
      endcase
    end
  end

  // State, filter and turn-counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hf_q    <= 1'b0;
      lf_q    <= 1'b0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
`ifdef ROBOT_STUCK_DETECT_EN
      turn_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hf_q    <= hf_d;
      lf_q    <= lf_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
`ifdef ROBOT_STUCK_DETECT_EN
      turn_q  <= turn_d;
`endif
    end
  end

  // Moore output decode from the current state
  always_comb begin
    a     = 1'b0;
    r     = 1'b0;
    dir   = 1'b0;
    stuck = 1'b0;
    case (state_q)
      S_FOLLOW:     a = 1'b1;
      S_SEARCH_ADV: a = 1'b1;
      S_AVOID: begin
        r   = 1'b1;
        dir = side_sel;
      end
      S_SEARCH_ROT: begin
        r   = 1'b1;
        dir = ~side_sel;
      end
`ifdef ROBOT_STUCK_DETECT_EN
      S_STUCK:      stuck = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_robot_wall_follower.sv
// Scoreboard bench for robot_wall_follower (DEB_LEN=3, TURN_MAX=8).
// Expected outputs are queued as each cycle's stimulus is driven and
// compared after the clock edge.
module tb_robot_wall_follower;

  logic       clk = 1'b0;
  logic       reset, enable, side_sel, h, l;
  logic       a, r, dir, stuck;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       a;
    logic       r;
    logic       dir;
    logic       stuck;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  robot_wall_follower #(.DEB_LEN(3), .TURN_MAX(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .side_sel (side_sel),
    .h        (h),
    .l        (l),
    .a        (a),
    .r        (r),
    .dir      (dir),
    .stuck    (stuck),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expectation
  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Moore output table for a given state code
  function automatic exp_t decode(input logic [2:0] s, input logic ss);
    exp_t e;
    e = '0;
    e.st = s;
    case (s)
      3'd1, 3'd4: e.a = 1'b1;
      3'd2: begin e.r = 1'b1; e.dir = ss;  end
      3'd3: begin e.r = 1'b1; e.dir = ~ss; end
      3'd5: e.stuck = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Drive n cycles of constant inputs, expecting state es after each edge
  task automatic step(input string tag, input logic hi, input logic li, input logic en,
                      input logic rst, input logic [2:0] es, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      h = hi; l = li; enable = en; reset = rst;
      sb_q.push_back(decode(es, side_sel));
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        check_eq({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq({tag, "_state"}, state, e.st);
        check_eq({tag, "_a"},     a,     e.a);
        check_eq({tag, "_r"},     r,     e.r);
        check_eq({tag, "_dir"},   dir,   e.dir);
        check_eq({tag, "_stuck"}, stuck, e.stuck);
        check_eq({tag, "_a_and_r"}, a & r, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; side_sel = 1'b0; h = 1'b1; l = 1'b1;

    // Reset with both sensors active, then idle while disabled
    step("rst",      1, 1, 0, 1, 3'd0, 2);
    step("dis",      1, 1, 0, 0, 3'd0, 4);

    // Wall found from reset: search alternates until lf settles
    step("rst2",     0, 1, 1, 1, 3'd0, 2);
    step("find",     0, 1, 1, 0, 3'd3, 1);
    step("find",     0, 1, 1, 0, 3'd4, 1);
    step("find",     0, 1, 1, 0, 3'd3, 1);
    step("follow",   0, 1, 1, 0, 3'd1, 3);

    // Short head glitch is filtered out
    step("glitch",   1, 1, 1, 0, 3'd1, 2);
    step("glitch",   0, 1, 1, 0, 3'd1, 1);

    // Sustained head obstacle reaches AVOID on the fourth edge
    step("obst",     1, 1, 1, 0, 3'd1, 3);
    step("obst",     1, 1, 1, 0, 3'd2, 1);
    step("clear",    0, 1, 1, 0, 3'd2, 3);
    step("clear",    0, 1, 1, 0, 3'd1, 1);

    // Wall lost: search rotate/advance alternation
    step("lost",     0, 0, 1, 0, 3'd1, 3);
    step("lost",     0, 0, 1, 0, 3'd3, 1);
    step("lost",     0, 0, 1, 0, 3'd4, 1);
    step("lost",     0, 0, 1, 0, 3'd3, 1);
    step("lost",     0, 0, 1, 0, 3'd4, 1);

    // Head held: AVOID, then STUCK when detection is built in
    step("hold",     1, 0, 1, 0, 3'd3, 1);
    step("hold",     1, 0, 1, 0, 3'd4, 1);
    step("hold",     1, 0, 1, 0, 3'd3, 1);
    step("hold",     1, 0, 1, 0, 3'd2, 1);
`ifdef ROBOT_STUCK_DETECT_EN
    step("avoid8",   1, 0, 1, 0, 3'd2, 7);
    step("stuck",    1, 0, 1, 0, 3'd5, 12);
    step("stuck_h0", 0, 0, 1, 0, 3'd5, 5);
`else
    step("avoid20",  1, 0, 1, 0, 3'd2, 19);
    step("rel",      0, 0, 1, 0, 3'd2, 3);
    step("rel",      0, 0, 1, 0, 3'd3, 1);
    step("rel",      0, 0, 1, 0, 3'd4, 1);
`endif
    step("off",      0, 0, 0, 0, 3'd0, 1);

    // Reset in the middle of AVOID restarts the turn count
    step("re",       1, 0, 1, 0, 3'd3, 1);
    step("re",       1, 0, 1, 0, 3'd4, 1);
    step("re",       1, 0, 1, 0, 3'd3, 1);
    step("re",       1, 0, 1, 0, 3'd2, 5);
    step("midrst",   1, 0, 1, 1, 3'd0, 1);
    step("re2",      1, 0, 1, 0, 3'd3, 1);
    step("re2",      1, 0, 1, 0, 3'd4, 1);
    step("re2",      1, 0, 1, 0, 3'd3, 1);
    step("re2",      1, 0, 1, 0, 3'd2, 8);
`ifdef ROBOT_STUCK_DETECT_EN
    step("re2_stk",  1, 0, 1, 0, 3'd5, 2);
`else
    step("re2_avd",  1, 0, 1, 0, 3'd2, 3);
`endif

    // Right-hand wall: direction polarity flips
    step("off2",     1, 0, 0, 0, 3'd0, 1);
    side_sel = 1'b1;
    step("right",    1, 0, 1, 0, 3'd2, 1);
    step("right",    0, 0, 1, 0, 3'd2, 3);
    step("right",    0, 0, 1, 0, 3'd3, 1);
    step("right",    0, 0, 1, 0, 3'd4, 1);

    check_eq("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/robot_wall_follower.md
ROBOT_WALL_FOLLOWER -- requirements
Module: robot_wall_follower

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset (clock `clk`, reset `reset`).
REQ-002 Parameter DEB_LEN, default 3, range 1..15: number of consecutive differing samples a sensor needs before its filtered value changes.
REQ-003 Parameter TURN_MAX, default 8, range 2..255: number of consecutive AVOID cycles before STUCK.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 enable  in  1  1 = run, 0 = force IDLE.
REQ-007 side_sel  in  1  0 = wall on left, 1 = wall on right; quasi-static, changed only while enable=0.
REQ-008 h  in  1  raw head (front) obstacle sensor.
REQ-009 l  in  1  raw side-wall sensor, on the side given by side_sel.
REQ-010 a  out  1  advance command.
REQ-011 r  out  1  rotate command.
REQ-012 dir  out  1  rotate direction: 1 = counter-clockwise, 0 = clockwise; 0 whenever r=0.
REQ-013 stuck  out  1  fault flag, high only in STUCK.
REQ-014 state  out  3  current state: IDLE=0, FOLLOW=1, AVOID=2, SEARCH_ROT=3, SEARCH_ADV=4, STUCK=5; codes 6..7 unused.

Function
REQ-015 Each sensor SHALL have an independent filter (filtered value hf/lf plus a counter), driven by h/l respectively.
REQ-016 The counter SHALL increment on each edge where the raw input differs from the filtered value and clear on any edge where they match.
REQ-017 The filtered value SHALL take the raw value on the edge that completes DEB_LEN consecutive differing samples, and the counter SHALL clear on that edge.
REQ-018 DEB_LEN=1 SHALL give a one-edge filter delay.
REQ-019 The state register SHALL update from hf/lf on every edge, so a stable raw change first sampled at edge k reaches state at edge k+DEB_LEN.
REQ-020 Outputs SHALL be Moore, decoded combinationally from state only.
REQ-021 Transitions with enable=1: IDLE/FOLLOW/SEARCH_ROT/SEARCH_ADV go to AVOID if hf; else FOLLOW if lf; else SEARCH_ROT (SEARCH_ROT→SEARCH_ADV).
REQ-022 AVOID SHALL stay in AVOID while hf=1; on hf=0 it SHALL go to FOLLOW if lf=1, else SEARCH_ROT.
REQ-023 STUCK SHALL hold regardless of h/l.
REQ-024 enable=0 SHALL force IDLE on the next edge from any state, and the filters SHALL keep running.
REQ-025 IDLE outputs: a=0 r=0.
REQ-026 FOLLOW outputs: a=1 r=0.
REQ-027 SEARCH_ADV outputs: a=1 r=0.
REQ-028 AVOID outputs: a=0 r=1, dir away from the wall (dir = side_sel).
REQ-029 SEARCH_ROT outputs: a=0 r=1, dir toward the wall (dir = ~side_sel).
REQ-030 STUCK outputs: a=0 r=0 stuck=1.
REQ-031 a and r SHALL never both be 1.
REQ-032 The turn counter SHALL be 0 on entry to AVOID and increment on each edge spent in AVOID with hf=1, saturating at TURN_MAX-1; its width SHALL be the minimum needed for TURN_MAX-1.
REQ-033 The turn counter SHALL clear on any edge whose next state is not AVOID.
REQ-034 Simultaneous hf=1 and lf=1 SHALL resolve to AVOID, since head has priority.

Reset
REQ-035 reset=1 at an edge SHALL clear state to IDLE and clear hf, lf, both filter counters and the turn counter, giving a=r=dir=stuck=0.
REQ-036 reset SHALL take priority over enable and all transitions, including mid-AVOID and STUCK.

Configuration
REQ-037 Macro ROBOT_STUCK_DETECT_EN defined: an edge in AVOID with hf=1 and turn counter = TURN_MAX-1 SHALL go to STUCK, i.e. STUCK after TURN_MAX AVOID cycles.
REQ-038 Macro ROBOT_STUCK_DETECT_EN undefined: the turn counter SHALL be absent, AVOID SHALL hold indefinitely while hf=1, stuck SHALL be tied 0 and STUCK SHALL be unreachable.

Verification (DEB_LEN=3, TURN_MAX=8, side_sel=0)
REQ-039 Reset with h=l=1, reset held 2 edges -> state=0, a=r=dir=stuck=0; after release with enable=0, state stays 0.
REQ-040 enable=1, l=1, h=0 from reset release -> hf=0 keeps state SEARCH_ROT/SEARCH_ADV alternating; lf=1 after edge 3; state=1, a=1 after edge 4.
REQ-041 In FOLLOW, h=1 for 2 cycles -> no state change, a stays 1; h=1 for 3 cycles -> state=2, r=1, dir=0 after the 4th edge.
REQ-042 In FOLLOW, l drops to 0 with h=0 -> after 4 edges state alternates 3,4,3,4 each edge: (r=1, dir=1) then (a=1).
REQ-043 h held 1 -> 8 edges in AVOID with r=1, dir=0, then state=5, stuck=1, a=r=0; releasing h keeps STUCK; enable=0 -> state=0 next edge. Without the macro: AVOID persists past 20 edges, stuck=0.
REQ-044 reset asserted on the 5th AVOID edge -> state=0 next edge; then h=1 held again -> a full 8 AVOID cycles before STUCK.
